// File: rtl/nand_target_pkg.sv
// Shared types and defaults for the NAND target pin engine.
package nand_target_pkg;

  localparam int IO_W          = 16;
  localparam int DEF_T_REA_CYC = 3;
  localparam int DEF_T_RHZ_CYC = 2;
  localparam int CNT_W         = 8;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_DRIVE,
    R_HOLD
  } rd_state_t;

  // One snapshot of every sampled pin; shifted as a unit through the synchronizer.
  typedef struct packed {
    logic            ce_n;
    logic            cle;
    logic            ale;
    logic            we_n;
    logic            re_n;
    logic [IO_W-1:0] io;
  } pins_t;

  // Idle bus levels: strobes and chip enable deasserted, latches and IO low.
  localparam pins_t PINS_IDLE = '{ce_n: 1'b1, cle: 1'b0, ale: 1'b0,
                                  we_n: 1'b1, re_n: 1'b1, io: '0};

endpackage

// File: rtl/nand_pin_sync.sv
// Two-flop synchronizer plus a "previous" stage for all NAND pins; edges are
// detected between stage 2 and previous so the IO bus stays aligned with WE#.
module nand_pin_sync
  import nand_target_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_n,
  input  logic            cle,
  input  logic            ale,
  input  logic            we_n,
  input  logic            re_n,
  input  logic [IO_W-1:0] io_in,
  output logic            ce_n_s,
  output logic            cle_s,
  output logic            ale_s,
  output logic [IO_W-1:0] io_s,
  output logic            we_rise,
  output logic            re_fall,
  output logic            re_rise,
  output logic            ce_rise
);

  pins_t raw, s1, s2, prev;

  assign raw = '{ce_n: ce_n, cle: cle, ale: ale, we_n: we_n, re_n: re_n, io: io_in};

  // Shift the pin snapshot; reset loads idle levels so release makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= PINS_IDLE;
      s2   <= PINS_IDLE;
      prev <= PINS_IDLE;
    end else begin
      // NOTE: non-blocking so all three stages advance together on the same edge.
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign ce_n_s  = s2.ce_n;
  assign cle_s   = s2.cle;
  assign ale_s   = s2.ale;
  assign io_s    = s2.io;
  assign we_rise = s2.we_n & ~prev.we_n;
  assign re_fall = ~s2.re_n & prev.re_n;
  assign re_rise = s2.re_n & ~prev.re_n;
  assign ce_rise = s2.ce_n & ~prev.ce_n;

endmodule

// File: rtl/nand_target_io.sv
// Device-side ONFI pin engine: decodes WE# strobes into command/address/data
// events and answers RE# strobes with read data after a programmable delay.
module nand_target_io
  import nand_target_pkg::*;
#(
  parameter int T_REA_CYC = DEF_T_REA_CYC,
  parameter int T_RHZ_CYC = DEF_T_RHZ_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ce_n,
  input  logic            cle,
  input  logic            ale,
  input  logic            we_n,
  input  logic            re_n,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic            io_oe,
  output logic            rb_n,
  input  logic            target_busy,
  output logic            cmd_valid,
  output logic            addr_valid,
  output logic            wdata_valid,
  output logic [IO_W-1:0] latch_data,
  output logic            rd_req,
  input  logic [IO_W-1:0] rd_data,
  output logic            proto_err
);

  localparam logic [CNT_W-1:0] REA_LOAD = CNT_W'(T_REA_CYC);
  localparam logic [CNT_W-1:0] RHZ_LOAD = CNT_W'(T_RHZ_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            ce_n_s, cle_s, ale_s;
  logic [IO_W-1:0] io_s;
  logic            we_rise, re_fall, re_rise, ce_rise;

  rd_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cap_pend, cap_nxt;
  logic [IO_W-1:0]  rd_buf, buf_nxt, out_nxt, latch_nxt;
  logic             oe_nxt, rd_req_nxt, perr_nxt;
  logic             cmd_nxt, addr_nxt, wd_nxt;
  logic             we_ev, re_fall_ev, re_rise_ev;

  nand_pin_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .ce_n    (ce_n),
    .cle     (cle),
    .ale     (ale),
    .we_n    (we_n),
    .re_n    (re_n),
    .io_in   (io_in),
    .ce_n_s  (ce_n_s),
    .cle_s   (cle_s),
    .ale_s   (ale_s),
    .io_s    (io_s),
    .we_rise (we_rise),
    .re_fall (re_fall),
    .re_rise (re_rise),
    .ce_rise (ce_rise)
  );

  // Strobes only count while the target is selected.
  assign we_ev      = we_rise & ~ce_n_s;
  assign re_fall_ev = re_fall & ~ce_n_s;
  assign re_rise_ev = re_rise & ~ce_n_s;

  // Next-state and output decode for the read FSM and write-event decoder.
  always_comb begin
    // NOTE: every value written here is defaulted first so no latch is inferred.
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_nxt    = 1'b0;
    buf_nxt    = rd_buf;
    out_nxt    = io_out;
    oe_nxt     = io_oe;
    rd_req_nxt = 1'b0;
    perr_nxt   = 1'b0;
    cmd_nxt    = 1'b0;
    addr_nxt   = 1'b0;
    wd_nxt     = 1'b0;
    latch_nxt  = latch_data;

    unique case (state)
      R_IDLE: begin
        if (re_fall_ev) begin
          rd_req_nxt = 1'b1;
          cnt_nxt    = REA_LOAD;
          cap_nxt    = 1'b1;
          state_nxt  = R_DELAY;
        end
      end
      R_DELAY: begin
        if (cap_pend) buf_nxt = rd_data;
        if (re_rise_ev) begin
          // Strobe too short to be served: abandon the read.
          perr_nxt  = 1'b1;
          oe_nxt    = 1'b0;
          state_nxt = R_IDLE;
        end else if (cnt == CNT_ONE) begin
          oe_nxt    = 1'b1;
          out_nxt   = cap_pend ? rd_data : rd_buf;
          state_nxt = R_DRIVE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      R_DRIVE: begin
        if (re_rise_ev) begin
          cnt_nxt   = RHZ_LOAD;
          state_nxt = R_HOLD;
        end
      end
      R_HOLD: begin
        if (re_fall_ev) begin
          // Back-to-back read: keep driving the old word until the new one lands.
          rd_req_nxt = 1'b1;
          cnt_nxt    = REA_LOAD;
          cap_nxt    = 1'b1;
          state_nxt  = R_DELAY;
        end else if (cnt == CNT_ONE) begin
          oe_nxt    = 1'b0;
          state_nxt = R_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: state_nxt = R_IDLE;
    endcase

    // Deselecting the target aborts any read in flight.
    if (ce_rise) begin
      oe_nxt    = 1'b0;
      state_nxt = R_IDLE;
    end

    if (we_ev) begin
      if (state != R_IDLE) begin
        perr_nxt = 1'b1;
      end else begin
        unique case ({cle_s, ale_s})
          2'b10:   cmd_nxt  = 1'b1;
          2'b01:   addr_nxt = 1'b1;
          2'b00:   wd_nxt   = 1'b1;
          default: perr_nxt = 1'b1;
        endcase
        if (cmd_nxt || addr_nxt || wd_nxt) latch_nxt = io_s;
      end
    end
  end

  // FSM state, read datapath and event pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= R_IDLE;
      cnt         <= '0;
      cap_pend    <= 1'b0;
      rd_buf      <= '0;
      io_out      <= '0;
      io_oe       <= 1'b0;
      rd_req      <= 1'b0;
      proto_err   <= 1'b0;
      cmd_valid   <= 1'b0;
      addr_valid  <= 1'b0;
      wdata_valid <= 1'b0;
      latch_data  <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cap_pend    <= cap_nxt;
      rd_buf      <= buf_nxt;
      io_out      <= out_nxt;
      io_oe       <= oe_nxt;
      rd_req      <= rd_req_nxt;
      proto_err   <= perr_nxt;
      cmd_valid   <= cmd_nxt;
      addr_valid  <= addr_nxt;
      wdata_valid <= wd_nxt;
      latch_data  <= latch_nxt;
    end
  end

  // Ready/busy pin mirrors the core request one cycle later.
  always_ff @(posedge clk) begin
    if (reset) rb_n <= 1'b1;
    else       rb_n <= ~target_busy;
  end

endmodule

// File: tb/tb_nand_target_io.sv
// Scoreboard bench for nand_target_io: stimulus pushes expected events with
// their expected cycle, a negedge monitor pops and compares each DUT event.
module tb_nand_target_io;
  import nand_target_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_n = 1'b1, cle = 1'b0, ale = 1'b0, we_n = 1'b1, re_n = 1'b1;
  logic        target_busy = 1'b0;
  logic [15:0] io_in = '0, rd_data = '0;
  logic [15:0] io_out, latch_data;
  logic        io_oe, rb_n, cmd_valid, addr_valid, wdata_valid, rd_req, proto_err;

  nand_target_io dut (
    .clk         (clk),
    .reset       (reset),
    .ce_n        (ce_n),
    .cle         (cle),
    .ale         (ale),
    .we_n        (we_n),
    .re_n        (re_n),
    .io_in       (io_in),
    .io_out      (io_out),
    .io_oe       (io_oe),
    .rb_n        (rb_n),
    .target_busy (target_busy),
    .cmd_valid   (cmd_valid),
    .addr_valid  (addr_valid),
    .wdata_valid (wdata_valid),
    .latch_data  (latch_data),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum {EV_CMD, EV_ADDR, EV_WDATA, EV_RDREQ, EV_PERR,
                EV_OE_RISE, EV_OE_FALL, EV_RB_FALL, EV_RB_RISE} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [15:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_t k, input logic [15:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s data=%h at cycle %0d, expected none",
               k.name(), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data !== d || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got %s data=%h cycle=%0d, expected %s data=%h cycle=%0d",
                 k.name(), d, cyc, e.kind.name(), e.data, e.cyc);
      end
    end
  endtask

  // Monitor: report every DUT event in a fixed order each cycle.
  logic prev_oe = 1'b0, prev_rb = 1'b1;
  always @(negedge clk) begin
    if (cmd_valid === 1'b1)   observe(EV_CMD, latch_data);
    if (addr_valid === 1'b1)  observe(EV_ADDR, latch_data);
    if (wdata_valid === 1'b1) observe(EV_WDATA, latch_data);
    if (rd_req === 1'b1)      observe(EV_RDREQ, 16'h0);
    if (proto_err === 1'b1)   observe(EV_PERR, 16'h0);
    if (io_oe === 1'b1 && prev_oe !== 1'b1) observe(EV_OE_RISE, io_out);
    if (io_oe !== 1'b1 && prev_oe === 1'b1) observe(EV_OE_FALL, 16'h0);
    if (rb_n !== 1'b1 && prev_rb === 1'b1)  observe(EV_RB_FALL, 16'h0);
    if (rb_n === 1'b1 && prev_rb !== 1'b1)  observe(EV_RB_RISE, 16'h0);
    prev_oe = io_oe;
    prev_rb = rb_n;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // WE# pulse; the event lands three edges after WE# is first sampled high.
  task automatic we_pulse(input logic c, input logic a, input logic [15:0] d,
                          input int lo, input int hi, input ev_kind_t k, input bit has_ev);
    cle   = c;
    ale   = a;
    io_in = d;
    we_n  = 1'b0;
    tick(lo);
    we_n = 1'b1;
    if (has_ev) expect_ev(k, (k == EV_PERR) ? 16'h0 : d, cyc + 3);
    tick(hi);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_io_oe"},      io_oe, 0);
    check({tag, "_io_out"},     io_out, 0);
    check({tag, "_rb_n"},       rb_n, 1);
    check({tag, "_cmd_valid"},  cmd_valid, 0);
    check({tag, "_rd_req"},     rd_req, 0);
    check({tag, "_proto_err"},  proto_err, 0);
    check({tag, "_latch_data"}, latch_data, 0);
  endtask

  logic [15:0] addr_v [5] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

  initial begin
    tick(3);
    check_reset_state("reset");
    reset = 1'b0;
    ce_n  = 1'b0;
    tick(4);

    // Ready/busy follows the core with one cycle of latency.
    target_busy = 1'b1;
    expect_ev(EV_RB_FALL, 16'h0, cyc + 1);
    tick(3);
    target_busy = 1'b0;
    expect_ev(EV_RB_RISE, 16'h0, cyc + 1);
    tick(3);

    // Command cycle.
    we_pulse(1'b1, 1'b0, 16'h0090, 4, 4, EV_CMD, 1'b1);

    // Address burst.
    for (int i = 0; i < 5; i++) we_pulse(1'b0, 1'b1, addr_v[i], 2, 2, EV_ADDR, 1'b1);

    // Write data, then illegal CLE=ALE=1.
    we_pulse(1'b0, 1'b0, 16'h1234, 2, 4, EV_WDATA, 1'b1);
    we_pulse(1'b1, 1'b1, 16'h00FF, 2, 4, EV_PERR, 1'b1);
    cle = 1'b0;
    ale = 1'b0;
    tick(2);

    // Normal read; rd_data changes after capture and must not be re-sampled.
    rd_data = 16'hA55A;
    re_n    = 1'b0;
    expect_ev(EV_RDREQ, 16'h0, cyc + 3);
    expect_ev(EV_OE_RISE, 16'hA55A, cyc + 6);
    tick(5);
    rd_data = 16'hFFFF;
    tick(3);
    re_n = 1'b1;
    expect_ev(EV_OE_FALL, 16'h0, cyc + 5);
    tick(6);

    // Short strobe: request then protocol error, no output enable.
    rd_data = 16'h1111;
    re_n    = 1'b0;
    expect_ev(EV_RDREQ, 16'h0, cyc + 3);
    expect_ev(EV_PERR, 16'h0, cyc + 4);
    tick(1);
    re_n = 1'b1;
    tick(6);

    // Deselected target ignores strobes.
    ce_n = 1'b1;
    tick(4);
    we_pulse(1'b1, 1'b0, 16'h0070, 2, 2, EV_CMD, 1'b0);
    cle  = 1'b0;
    re_n = 1'b0;
    tick(8);
    re_n = 1'b1;
    tick(4);
    ce_n = 1'b0;
    tick(4);

    // Reset while driving read data.
    rd_data = 16'h5AA5;
    re_n    = 1'b0;
    expect_ev(EV_RDREQ, 16'h0, cyc + 3);
    expect_ev(EV_OE_RISE, 16'h5AA5, cyc + 6);
    tick(8);
    reset = 1'b1;
    re_n  = 1'b1;
    expect_ev(EV_OE_FALL, 16'h0, cyc + 1);
    tick(3);
    check_reset_state("mid_reset");
    reset = 1'b0;
    tick(12);

    check("expected_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
